// File: rtl/uart_rx_if.sv
// Host-side view of the UART receiver: the holding register and its read strobe.
//
// Handshake: `valid` is high while the holding register has an unread byte.
// The host consumes it by pulsing `rd` for one cycle. `valid` drops on the edge
// that samples `rd`=1. `rd` while `valid`=0 is ignored. `dout` and `frame_err`
// keep their last values until the next frame completes.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rd;
    logic [DBIT-1:0] dout;
    logic            valid;
    logic            frame_err;
    logic            overrun;
    logic            rx_done_tick;

    // host logic reading the receiver
    modport master (
        output rd,
        input  dout, valid, frame_err, overrun, rx_done_tick
    );

    // the receiver itself
    modport slave (
        input  rd,
        output dout, valid, frame_err, overrun, rx_done_tick
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick. It deframes serial data
// LSB first into a one-entry holding register that carries valid, frame-error
// and sticky overrun flags. state_dbg exposes the FSM state for observation.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    uart_rx_if.slave   bus,
    output logic [1:0] state_dbg
);
    localparam int              NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0]   N_LAST = NW'(DBIT - 1);
    localparam logic [3:0]      S_MID  = 4'd7;
    localparam logic [3:0]      S_LAST = 4'd15;
    localparam logic [3:0]      S_STOP = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            done;
    logic            rx_meta, rxs;

    logic [DBIT-1:0] dout_q;
    logic            valid_q, frame_err_q, overrun_q, done_q;

    assign bus.dout         = dout_q;
    assign bus.valid        = valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.overrun      = overrun_q;
    assign bus.rx_done_tick = done_q;
    assign state_dbg        = state_q;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // FSM state, tick counter, bit counter and shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    // Next-state logic: start is detected without a tick, everything else advances on s_tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // Mid start bit: still low means a real start, high means a glitch.
                        if (!rxs) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        b_d = {rxs, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a completion loads it, a read strobe empties it; completion wins over a read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= done;
            if (done) begin
                dout_q      <= b_q;
                frame_err_q <= ~rxs;
                valid_q     <= 1'b1;
                if (valid_q && !bus.rd) begin
                    overrun_q <= 1'b1;
                end else if (bus.rd) begin
                    overrun_q <= 1'b0;
                end
            end else if (bus.rd && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of 8N1 frames with expected holding
// register contents, plus hand sequences for glitches, sparse ticks and reset.
module tb_uart_rx;
    logic       clock;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [1:0] state_dbg;

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .s_tick    (s_tick),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int tests    = 0;
    int failed   = 0;
    int done_cnt = 0;
    int tick_div = 1;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- tick generator ----------------
    initial begin
        int tick_cnt;
        tick_cnt = 0;
        s_tick   = 1'b1;
        forever begin
            @(negedge clock);
            if (tick_cnt >= tick_div - 1) begin
                tick_cnt = 0;
                s_tick   = 1'b1;
            end else begin
                tick_cnt++;
                s_tick = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        int done_run;
        logic [7:0] e;
        done_run = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                done_run = 0;
            end else if (bus.rx_done_tick) begin
                done_run++;
                if (done_run == 1) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        check("spurious_done", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_dout", bus.dout, e);
                    end
                end else begin
                    check("done_pulse_width", done_run, 1);
                end
            end else begin
                done_run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives one frame at bc cycles per bit, changing rx on negedges. With one
    // tick per cycle the frame completes on the posedge right after the 155th
    // negedge following the falling edge; rd_at_done targets that edge.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit rd_at_done,
                              input int bc, input bit chk_lat, input int stop_at);
        logic [9:0] bits;
        bits = {stop_ok, data, 1'b0};
        for (int c = 0; c < stop_at; c++) begin
            @(negedge clock);
            if (chk_lat && c == 155) check("done_latency", bus.rx_done_tick, 1);
            rx     = bits[c / bc];
            bus.rd = rd_at_done && (c == 154);
        end
        bus.rd = 1'b0;
        rx     = 1'b1;
    endtask

    task automatic pulse_rd();
        @(negedge clock);
        bus.rd = 1'b1;
        @(negedge clock);
        bus.rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dout"}, bus.dout, 0);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
        check({tag, "_overrun"}, bus.overrun, 0);
        check({tag, "_done"}, bus.rx_done_tick, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         rd_at_done;
        bit         rd_after;
        logic [7:0] exp_dout;
        bit         exp_valid;
        bit         exp_ferr;
        bit         exp_ovr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h34, 1'b1, 1'b0, 1'b0, 8'h34, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h56, 1'b1, 1'b1, 1'b0, 8'h56, 1'b1, 1'b0, 1'b0};

        reset  = 1'b1;
        rx     = 1'b1;
        bus.rd = 1'b0;
        idle(3);
        check_reset_values("reset");
        reset = 1'b0;
        idle(5);

        // table-driven frames, one tick per cycle
        for (int i = 0; i < 6; i++) begin
            base = done_cnt;
            exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].rd_at_done, 16, 1'b1, 160);
            check($sformatf("v%0d_dout", i), bus.dout, vecs[i].exp_dout);
            check($sformatf("v%0d_valid", i), bus.valid, vecs[i].exp_valid);
            check($sformatf("v%0d_frame_err", i), bus.frame_err, vecs[i].exp_ferr);
            check($sformatf("v%0d_overrun", i), bus.overrun, vecs[i].exp_ovr);
            check($sformatf("v%0d_done_count", i), done_cnt - base, 1);
            idle(32);
            if (vecs[i].rd_after) begin
                pulse_rd();
                check($sformatf("v%0d_valid_after_rd", i), bus.valid, 0);
                check($sformatf("v%0d_dout_hold", i), bus.dout, vecs[i].exp_dout);
                check($sformatf("v%0d_ferr_hold", i), bus.frame_err, vecs[i].exp_ferr);
            end
        end

        // glitch: 4-cycle low pulse must be rejected, 0x56 stays unread
        base = done_cnt;
        @(negedge clock);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        check("glitch_done_count", done_cnt - base, 0);
        check("glitch_state_idle", state_dbg, 0);
        check("glitch_valid", bus.valid, 1);
        check("glitch_dout", bus.dout, 8'h56);
        pulse_rd();
        check("glitch_valid_after_rd", bus.valid, 0);
        check("rd_clears_overrun", bus.overrun, 0);
        pulse_rd();
        check("rd_when_empty_valid", bus.valid, 0);

        // sparse ticks: every 3rd cycle, back-to-back 0x00 and 0xFF
        tick_div = 3;
        idle(6);
        base = done_cnt;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 1'b0, 48, 1'b0, 480);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0, 48, 1'b0, 480);
        idle(10);
        check("sparse_done_count", done_cnt - base, 2);
        check("sparse_dout", bus.dout, 8'hFF);
        check("sparse_valid", bus.valid, 1);
        check("sparse_overrun", bus.overrun, 1);
        check("sparse_frame_err", bus.frame_err, 0);
        pulse_rd();
        tick_div = 1;
        idle(6);

        // reset after bit 3 of 0xC7, then a clean 0x81
        base = done_cnt;
        send_frame(8'hC7, 1'b1, 1'b0, 16, 1'b0, 80);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("midreset");
        idle(3);
        reset = 1'b0;
        idle(20);
        check("midreset_no_byte", done_cnt - base, 0);
        check("midreset_state_idle", state_dbg, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 16, 1'b1, 160);
        idle(4);
        check("after_reset_dout", bus.dout, 8'h81);
        check("after_reset_valid", bus.valid, 1);
        check("after_reset_done_count", done_cnt - base, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path. It consumes the 16x-oversampling tick from the baud-rate generator and deframes 8N1 serial data, LSB first. Each byte lands in a one-entry holding register with valid, frame-error and overrun flags, and the register is read by the host logic with a single-cycle read strobe. The block sits between the `rx` pin and the host, as the receive-side counterpart of the baud-rate generator.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: oversampling ticks spent in the stop bit (16 = 1 stop bit).

Ports:
- `clock`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high. It clears every register immediately.
- `rx`, input, 1: asynchronous serial line. Idle level is 1.
- `s_tick`, input, 1: one-cycle sampling strobe at 16x baud, synchronous to `clock`.
- `rd`, input, 1: read strobe. It consumes the holding register.
- `dout`, output, `DBIT`: received byte.
- `valid`, output, 1: holding register contains an unread byte.
- `frame_err`, output, 1: stop bit of the byte in `dout` sampled as 0.
- `overrun`, output, 1: sticky flag, set when a byte arrived while `valid` was still 1.
- `rx_done_tick`, output, 1: one-cycle pulse, asserted when a frame completes.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer with reset value 1. All decisions use the synchronized bit `rxs`.
- **Counters:** tick counter `s` is 4 bits and wraps at 16. Bit counter `n` is `$clog2(DBIT)` bits. Shift register `b` is `DBIT` bits.
- **State machine:** states are IDLE, START, DATA, STOP, with reset state IDLE. Counters and the shift register advance only in cycles where `s_tick`=1.
  - IDLE: when `rxs`=0, go to START with `s`=0. Detection does not wait for a tick.
  - START: on each tick, if `s`==7, check `rxs`. If `rxs`=0, go to DATA with `s`=0 and `n`=0. If `rxs`=1, this is a false start and the FSM returns to IDLE. Otherwise increment `s`.
  - DATA: on each tick, if `s`==15, set `b` ← {`rxs`, `b[DBIT-1:1]`} and `s`=0. Then, if `n`==DBIT-1, go to STOP; otherwise increment `n`. Otherwise increment `s`.
  - STOP: on each tick, if `s`==SB_TICK-1, capture the stop sample `rxs`, pulse `rx_done_tick`, and go to IDLE. Otherwise increment `s`.
- **Sample point:** data and stop bits are sampled at mid-bit, 16 ticks after the start mid-point.
- **Holding register, on frame completion:**
  - `dout` ← `b`.
  - `frame_err` ← ~stop sample.
  - `valid` ← 1.
  - If `valid` was 1 and `rd`=0 in the same cycle, `overrun` ← 1. The old byte is overwritten.
- **Read:** `rd`=1 with no completion clears `valid` and `overrun`. `dout` and `frame_err` hold their values.
- **Simultaneous events:**
  - `rd` and completion in the same cycle: the new byte is loaded, `valid` stays 1, and `overrun` is cleared rather than set.
  - `rd` while `valid`=0: no effect.
- **Frame error:** the byte is still delivered. Returning to IDLE happens regardless of the stop sample, so a 0 line re-triggers START immediately.
- **Reset mid-frame:** the FSM goes to IDLE and the partial byte is discarded. After release, reception restarts only on a fresh falling edge seen by the synchronizer.

## Timing
- **Reset values:** `dout`=0, `valid`=0, `frame_err`=0, `overrun`=0, `rx_done_tick`=0, and synchronizer=11.
- **Registered outputs:** all outputs are registered with no combinational path from inputs.
- **Start detection:** a falling edge of `rx` reaches `rxs` 2 cycles later. START is entered on the next edge.
- **Frame length:** a frame takes 8 + 16·DBIT + SB_TICK ticks after START entry. That is 152 ticks for the defaults.
- **Completion timing:** `rx_done_tick`, `valid`, `dout` and `frame_err` update on the same edge, the one that consumes the final stop tick. `rx_done_tick` is high for exactly one cycle.
- **Read timing:** `valid` falls on the edge that samples `rd`=1.
- **Tick rate:** `s_tick` may be held high continuously (16 cycles per bit). The FSM must be correct for any tick spacing of 1 or more cycles.

## Test plan
- **Single byte:** with `s_tick` every cycle, drive 0x55 as 8N1 at 16 cycles per bit. Required: one `rx_done_tick` pulse, `dout`=0x55, `valid`=1, `frame_err`=0, `overrun`=0. Then pulse `rd`: `valid`=0.
- **Glitch rejection:** a 4-tick low glitch on idle `rx`. Required: false start, no `rx_done_tick`, FSM back in IDLE, and `valid` unchanged.
- **Framing error:** send 0xA3 with the stop bit held 0. Required: `dout`=0xA3, `frame_err`=1, `valid`=1. The next frame, 0x0F with a good stop bit, is received with `frame_err`=0.
- **Overrun and simultaneous read:** send 0x12 then 0x34 without `rd`. Required: `dout`=0x34, `overrun`=1. Then send 0x56 with `rd` asserted on its completion cycle. Required: `dout`=0x56, `valid`=1, `overrun`=0.
- **Sparse ticks:** `s_tick` every 3rd cycle (48 cycles per bit), back-to-back bytes 0x00 and 0xFF. Required: both received, two `rx_done_tick` pulses.
- **Reset mid-frame:** assert `reset` after bit 3 of 0xC7, then release and send 0x81. Required: outputs are at their reset values during reset, no byte is delivered for the aborted frame, and `dout`=0x81 after the new frame.
